// File: rtl/udp_rx_dispatch.sv
// udp_rx_dispatch
//   Pairs each received UDP payload packet with its in-order lookup result
//   (hit, connectionId) and steers hits to one of NUM_CHANNELS output streams
//   chosen by the low bits of connectionId. Misses and packets for disabled
//   channels are consumed and discarded.
//
//   Optional feature macro: ZEUS_RX_DISPATCH_STATS_EN
//     defined   -> saturating rx/miss/disabled packet counters are built
//     undefined -> stat_* outputs are tied to zero, no counter flops
//
//   Handshake semantics (all streams): a transfer happens on a rising clock
//   edge where valid and ready are both high. Valid never depends on ready.
//   The payload ready depends combinationally only on m00_axis_tready[ch]
//   of the channel owning the current packet.

module udp_rx_dispatch #(
   parameter int DATA_WIDTH    = 512,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int CONN_ID_WIDTH = 18,
   parameter int NUM_CHANNELS  = 4,
   parameter int STAT_WIDTH    = 32
) (
   input  logic                      s00_axis_aclk,
   input  logic                      s00_axis_aresetn,

   input  logic                      s00_axis_tvalid,
   input  logic                      s00_axis_tlast,
   input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]     s00_axis_tstrb,
   output logic                      s00_axis_tready,

   input  logic                      s01_axis_lookup_valid,
   input  logic                      s01_axis_lookup_hit,
   input  logic [CONN_ID_WIDTH-1:0]  s01_axis_lookup_connectionId,
   output logic                      s01_axis_lookup_ready,

   input  logic [NUM_CHANNELS-1:0]   channel_enable,

   output logic [NUM_CHANNELS-1:0]   m00_axis_tvalid,
   input  logic [NUM_CHANNELS-1:0]   m00_axis_tready,
   output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [KEEP_WIDTH-1:0]     m00_axis_tstrb,
   output logic                      m00_axis_tlast,
   output logic [CONN_ID_WIDTH-1:0]  m00_axis_tuser,

   output logic [STAT_WIDTH-1:0]     stat_rx_pkts,
   output logic [STAT_WIDTH-1:0]     stat_drop_miss,
   output logic [STAT_WIDTH-1:0]     stat_drop_disabled
);

   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORWARD = 2'd1,
      DROP    = 2'd2
   } state_t;

   state_t                    state;
   logic [CH_W-1:0]           ch;
   logic [CONN_ID_WIDTH-1:0]  conn_id;

   logic [CH_W-1:0]           lookup_ch;
   logic                      lookup_fire;
   logic                      lookup_fwd;
   logic                      beat_last_fire;

   // With a single channel there are no select bits; everything goes to 0.
   assign lookup_ch      = (NUM_CHANNELS > 1) ? s01_axis_lookup_connectionId[CH_W-1:0] : '0;
   assign lookup_fire    = (state == IDLE) && s01_axis_lookup_valid;
   assign lookup_fwd     = s01_axis_lookup_hit && channel_enable[lookup_ch];
   assign beat_last_fire = s00_axis_tvalid && s00_axis_tready && s00_axis_tlast;

   // Packet FSM: the hit/enable decision is taken once at the lookup handshake
   // and folded into the state, so later enable changes cannot affect the packet.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state   <= IDLE;
         ch      <= '0;
         conn_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (lookup_fire) begin
                  conn_id <= s01_axis_lookup_connectionId;
                  ch      <= lookup_ch;
                  state   <= lookup_fwd ? FORWARD : DROP;
               end
            end
            FORWARD, DROP: begin
               if (beat_last_fire) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake steering: only the owning channel's ready reaches the payload ready.
   always_comb begin
      s01_axis_lookup_ready = (state == IDLE);
      s00_axis_tready       = 1'b0;
      m00_axis_tvalid       = '0;
      case (state)
         FORWARD: begin
            s00_axis_tready     = m00_axis_tready[ch];
            m00_axis_tvalid[ch] = s00_axis_tvalid;
         end
         DROP: begin
            s00_axis_tready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign m00_axis_tdata = s00_axis_tdata;
   assign m00_axis_tstrb = s00_axis_tstrb;
   assign m00_axis_tlast = s00_axis_tlast;
   assign m00_axis_tuser = conn_id;

`ifdef ZEUS_RX_DISPATCH_STATS_EN
   logic [STAT_WIDTH-1:0] rx_cnt;
   logic [STAT_WIDTH-1:0] miss_cnt;
   logic [STAT_WIDTH-1:0] dis_cnt;

   // Saturating packet counters, classified once per packet at the lookup handshake.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         rx_cnt   <= '0;
         miss_cnt <= '0;
         dis_cnt  <= '0;
      end else if (lookup_fire) begin
         if (!s01_axis_lookup_hit) begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_WIDTH'(1);
         end else if (lookup_fwd) begin
            if (rx_cnt != '1) rx_cnt <= rx_cnt + STAT_WIDTH'(1);
         end else begin
            if (dis_cnt != '1) dis_cnt <= dis_cnt + STAT_WIDTH'(1);
         end
      end
   end

   assign stat_rx_pkts       = rx_cnt;
   assign stat_drop_miss     = miss_cnt;
   assign stat_drop_disabled = dis_cnt;
`else
   assign stat_rx_pkts       = '0;
   assign stat_drop_miss     = '0;
   assign stat_drop_disabled = '0;
`endif

endmodule

// File: tb/tb_udp_rx_dispatch.sv
// Testbench for udp_rx_dispatch (default parameters, NUM_CHANNELS=4).
// Expected stat values follow ZEUS_RX_DISPATCH_STATS_EN when it is defined.

module tb_udp_rx_dispatch;

   localparam int DW    = 512;
   localparam int KW    = DW / 8;
   localparam int IDW   = 18;
   localparam int NCH   = 4;
   localparam int SW    = 32;
   localparam int EXP_W = 2 + IDW + 1 + KW + DW;
`ifdef ZEUS_RX_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic            s00_axis_tvalid = 1'b0;
   logic            s00_axis_tlast  = 1'b0;
   logic [DW-1:0]   s00_axis_tdata  = '0;
   logic [KW-1:0]   s00_axis_tstrb  = '0;
   logic            s00_axis_tready;
   logic            lk_valid = 1'b0;
   logic            lk_hit   = 1'b0;
   logic [IDW-1:0]  lk_id    = '0;
   logic            lk_ready;
   logic [NCH-1:0]  channel_enable  = '1;
   logic [NCH-1:0]  m00_axis_tvalid;
   logic [NCH-1:0]  m00_axis_tready = '0;
   logic [DW-1:0]   m00_axis_tdata;
   logic [KW-1:0]   m00_axis_tstrb;
   logic            m00_axis_tlast;
   logic [IDW-1:0]  m00_axis_tuser;
   logic [SW-1:0]   stat_rx_pkts;
   logic [SW-1:0]   stat_drop_miss;
   logic [SW-1:0]   stat_drop_disabled;

   udp_rx_dispatch dut (
      .s00_axis_aclk                (clk),
      .s00_axis_aresetn             (rst_n),
      .s00_axis_tvalid              (s00_axis_tvalid),
      .s00_axis_tlast               (s00_axis_tlast),
      .s00_axis_tdata               (s00_axis_tdata),
      .s00_axis_tstrb               (s00_axis_tstrb),
      .s00_axis_tready              (s00_axis_tready),
      .s01_axis_lookup_valid        (lk_valid),
      .s01_axis_lookup_hit          (lk_hit),
      .s01_axis_lookup_connectionId (lk_id),
      .s01_axis_lookup_ready        (lk_ready),
      .channel_enable               (channel_enable),
      .m00_axis_tvalid              (m00_axis_tvalid),
      .m00_axis_tready              (m00_axis_tready),
      .m00_axis_tdata               (m00_axis_tdata),
      .m00_axis_tstrb               (m00_axis_tstrb),
      .m00_axis_tlast               (m00_axis_tlast),
      .m00_axis_tuser               (m00_axis_tuser),
      .stat_rx_pkts                 (stat_rx_pkts),
      .stat_drop_miss               (stat_drop_miss),
      .stat_drop_disabled           (stat_drop_disabled)
   );

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   bit mon_en    = 1'b0;
   bit drop_mode = 1'b0;
   bit bp_mode   = 1'b0;
   int fire_c    = 0;
   int exp_rx = 0, exp_miss = 0, exp_dis = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [63:0] sv(input int v);
      return STATS ? 64'(v) : 64'd0;
   endfunction

   // Output monitor: every downstream handshake pops one expected beat.
   always @(negedge clk) begin
      logic [EXP_W-1:0] obs;
      logic [EXP_W-1:0] want;
      logic [1:0]       ci;
      if (rst_n && mon_en) begin
         checks++;
         if ($countones(m00_axis_tvalid) > 1) begin
            errors++;
            $display("FAIL onehot: m00_tvalid=%b", m00_axis_tvalid);
         end
         for (int i = 0; i < NCH; i++) begin
            if (m00_axis_tvalid[i] && m00_axis_tready[i]) begin
               ci  = i[1:0];
               obs = {ci, m00_axis_tuser, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: ch=%0d user=%h got beat, want none", i, m00_axis_tuser);
               end else begin
                  want = exp_q.pop_front();
                  if (obs !== want) begin
                     errors++;
                     $display("FAIL beat: got=%h want=%h", obs, want);
                  end
               end
            end
         end
         if (drop_mode && s00_axis_tvalid) begin
            checks++;
            if (s00_axis_tready !== 1'b1 || m00_axis_tvalid !== '0) begin
               errors++;
               $display("FAIL drop_beat: tready=%b m00_tvalid=%b want 1/0000", s00_axis_tready, m00_axis_tvalid);
            end
         end
         if (bp_mode) begin
            checks++;
            if (s00_axis_tready !== m00_axis_tready[3]) begin
               errors++;
               $display("FAIL bp_ready: tready=%b want=%b", s00_axis_tready, m00_axis_tready[3]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] s, input logic l);
      bit ok = 1'b0;
      int n  = 0;
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = d;
      s00_axis_tstrb  = s;
      s00_axis_tlast  = l;
      while (!ok && n < 100) begin
         @(negedge clk);
         if (s00_axis_tready === 1'b1) begin
            ok = 1'b1;
            fire_c = cyc;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("beat_timeout", 64'd0, 64'd1);
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
   endtask

   task automatic do_lookup(input logic hit, input logic [IDW-1:0] id);
      bit ok = 1'b0;
      int n  = 0;
      lk_valid = 1'b1;
      lk_hit   = hit;
      lk_id    = id;
      while (!ok && n < 100) begin
         @(negedge clk);
         if (lk_ready === 1'b1) ok = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("lookup_timeout", 64'd0, 64'd1);
      lk_valid = 1'b0;
   endtask

   task automatic send_pkt(input int nb, input logic fwd, input logic [1:0] ch,
                           input logic [IDW-1:0] id, output int first_c, output int last_c);
      logic [DW-1:0] d;
      logic [KW-1:0] s;
      logic [31:0]   tag;
      logic          l;
      first_c = 0;
      last_c  = 0;
      for (int b = 0; b < nb; b++) begin
         tag = $urandom;
         d   = {16{tag}};
         s   = {$urandom, $urandom};
         l   = (b == nb - 1);
         if (fwd) exp_q.push_back({ch, id, l, s, d});
         drive_beat(d, s, l);
         if (b == 0) first_c = fire_c;
         last_c = fire_c;
      end
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_rx"},   64'(stat_rx_pkts),       sv(exp_rx));
      check({tag, "_miss"}, 64'(stat_drop_miss),     sv(exp_miss));
      check({tag, "_dis"},  64'(stat_drop_disabled), sv(exp_dis));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s00_tready"}, 64'(s00_axis_tready), 64'd0);
      check({tag, "_lk_ready"},   64'(lk_ready),        64'd1);
      check({tag, "_m00_tvalid"}, 64'(m00_axis_tvalid), 64'd0);
      check({tag, "_tuser"},      64'(m00_axis_tuser),  64'd0);
      check({tag, "_stat_rx"},    64'(stat_rx_pkts),    64'd0);
      check({tag, "_stat_miss"},  64'(stat_drop_miss),  64'd0);
      check({tag, "_stat_dis"},   64'(stat_drop_disabled), 64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic           hit;
      logic [IDW-1:0] id;
      logic [3:0]     en;
      logic [3:0]     rdy;
      int             nb;
      logic           flip;  // invert channel_enable after the lookup handshake
      logic           fwd;   // expected: forwarded
      logic [1:0]     ch;    // expected channel
   } vec_t;

   localparam int NV = 8;
   vec_t tbl[NV];

   // Global watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main test ----------------
   initial begin
      int f0, l0, lprev;
      bit bp_done;
      logic [DW-1:0] d;
      logic [KW-1:0] s;

      tbl[0] = '{1'b1, 18'h00006, 4'b1111, 4'b1111, 3, 1'b0, 1'b1, 2'd2};
      tbl[1] = '{1'b0, 18'h00155, 4'b1111, 4'b0000, 2, 1'b0, 1'b0, 2'd1};
      tbl[2] = '{1'b1, 18'h00001, 4'b1101, 4'b1111, 1, 1'b0, 1'b0, 2'd1};
      tbl[3] = '{1'b1, 18'h00001, 4'b1111, 4'b0010, 1, 1'b0, 1'b1, 2'd1};
      tbl[4] = '{1'b1, 18'h3FFFF, 4'b1111, 4'b1111, 2, 1'b0, 1'b1, 2'd3};
      tbl[5] = '{1'b0, 18'h00002, 4'b0000, 4'b0000, 1, 1'b0, 1'b0, 2'd2};
      tbl[6] = '{1'b1, 18'h00010, 4'b0001, 4'b1111, 4, 1'b1, 1'b1, 2'd0};
      tbl[7] = '{1'b1, 18'h0002A, 4'b1011, 4'b1111, 2, 1'b0, 1'b0, 2'd2};

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;

      // Table-driven packets.
      for (int r = 0; r < NV; r++) begin
         channel_enable  = tbl[r].en;
         m00_axis_tready = tbl[r].rdy;
         do_lookup(tbl[r].hit, tbl[r].id);
         if (tbl[r].flip) channel_enable = ~tbl[r].en;
         drop_mode = !tbl[r].fwd;
         send_pkt(tbl[r].nb, tbl[r].fwd, tbl[r].ch, tbl[r].id, f0, l0);
         drop_mode = 1'b0;
         if (tbl[r].fwd) exp_rx++;
         else if (!tbl[r].hit) exp_miss++;
         else exp_dis++;
         @(negedge clk);
         check($sformatf("row%0d_drained", r), 64'(exp_q.size()), 64'd0);
         check_stats($sformatf("row%0d", r));
         @(posedge clk);
         #1;
      end

      // Backpressure on channel 3 with channel 0 ready held high.
      channel_enable  = 4'b1111;
      m00_axis_tready = 4'b0001;
      do_lookup(1'b1, 18'h00003);
      bp_mode = 1'b1;
      bp_done = 1'b0;
      fork
         begin
            send_pkt(5, 1'b1, 2'd3, 18'h00003, f0, l0);
            bp_done = 1'b1;
         end
         begin
            for (int k = 0; k < 200 && !bp_done; k++) begin
               @(posedge clk);
               #1 m00_axis_tready[3] = ~m00_axis_tready[3];
            end
         end
      join
      bp_mode = 1'b0;
      exp_rx++;
      m00_axis_tready = 4'b1111;
      @(negedge clk);
      check("bp_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;

      // Payload presented five cycles ahead of its lookup result.
      d = {16{32'hCAFE0001}};
      s = {$urandom, $urandom};
      exp_q.push_back({2'd0, 18'h00000, 1'b1, s, d});
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = d;
      s00_axis_tstrb  = s;
      s00_axis_tlast  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("early_hold%0d", k), 64'(s00_axis_tready), 64'd0);
         @(posedge clk);
         #1;
      end
      lk_valid = 1'b1;
      lk_hit   = 1'b1;
      lk_id    = 18'h00000;
      @(negedge clk);
      check("early_lk_cycle_tready", 64'(s00_axis_tready), 64'd0);
      check("early_lk_ready", 64'(lk_ready), 64'd1);
      @(posedge clk);
      #1 lk_valid = 1'b0;
      @(negedge clk);
      check("early_after_lk_tready", 64'(s00_axis_tready), 64'd1);
      @(posedge clk);
      #1;
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      exp_rx++;

      // Four back-to-back packets to channels 0..3.
      lprev = 0;
      for (int c = 0; c < 4; c++) begin
         logic [IDW-1:0] bid;
         bid = IDW'((c * 32'h40) + c);
         do_lookup(1'b1, bid);
         send_pkt(2, 1'b1, 2'(c), bid, f0, l0);
         if (c > 0) check($sformatf("b2b_gap%0d", c), 64'(f0 - lprev), 64'd2);
         check($sformatf("b2b_thru%0d", c), 64'(l0 - f0), 64'd1);
         lprev = l0;
         exp_rx++;
      end
      @(negedge clk);
      check("b2b_drained", 64'(exp_q.size()), 64'd0);
      check_stats("b2b");
      @(posedge clk);
      #1;

      // Reset asserted during the second beat of a 4-beat packet.
      do_lookup(1'b1, 18'h00002);
      d = {16{32'h5EED0001}};
      s = {$urandom, $urandom};
      exp_q.push_back({2'd2, 18'h00002, 1'b0, s, d});
      drive_beat(d, s, 1'b0);
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = {16{32'h5EED0002}};
      s00_axis_tlast  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      s00_axis_tvalid = 1'b0;
      exp_rx = 0;
      exp_miss = 0;
      exp_dis = 0;
      check("midreset_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fresh packet after reset.
      do_lookup(1'b1, 18'h002A5);
      send_pkt(2, 1'b1, 2'd1, 18'h002A5, f0, l0);
      exp_rx++;
      @(negedge clk);
      check("post_reset_drained", 64'(exp_q.size()), 64'd0);
      check_stats("post_reset");
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
